// File: rtl/ja_tester_pkg.sv
// Shared constants for the ja header loopback tester.
// FSM encodings, pin indices, tristate codes and the expected-response helper.
package ja_tester_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_DRIVE   = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_SAMPLE  = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    localparam int PIN_A = 0;
    localparam int PIN_B = 1;
    localparam int PIN_C = 2;

    localparam logic T_HIZ   = 1'b1;
    localparam logic T_DRIVE = 1'b0;

    localparam logic [2:0] JA_T_RUN  = {T_HIZ, T_DRIVE, T_DRIVE};
    localparam logic [2:0] JA_T_IDLE = {T_HIZ, T_HIZ, T_HIZ};

    // Response expected from a healthy and_gate for vector {b,a}.
    function automatic logic exp_c(input logic [1:0] vec);
        return vec[PIN_A] & vec[PIN_B];
    endfunction

endpackage

// File: rtl/ja_pin_tester_if.sv
// Control/status and IOBUF pin bundle of the ja tester.
// slave: the tester itself; master: whoever starts it and owns the pins.
interface ja_pin_tester_if;

    logic       start;
    logic [2:0] ja_out;
    logic [2:0] ja_t;
    logic [2:0] ja_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;

    modport slave (
        input  start,
        input  ja_in,
        output ja_out,
        output ja_t,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_mask
    );

    modport master (
        output start,
        output ja_in,
        input  ja_out,
        input  ja_t,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_mask
    );

endinterface

// File: rtl/ja_pin_tester_sync.sv
// Single-bit STAGES-deep synchroniser, async active-high reset to 0.
// Ports: clk, rst, d (async input), q (synchronised output).
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/ja_pin_tester.sv
// Drives all four (a,b) vectors onto ja[1:0], checks c on ja[2] against a&b.
// Ports: clk, rst (async high), bus (slave: start/ja_in in; pins + status out).
module ja_pin_tester
    import ja_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int TURN_CYCLES   = 2
) (
    input  logic clk,
    input  logic rst,
    ja_pin_tester_if.slave bus
);

    localparam int CW = 9;
    localparam logic [CW-1:0] SETTLE_LAST =
        CW'(SETTLE_CYCLES + SYNC_STAGES - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);

    state_t        state;
    logic [1:0]    vec;
    logic [CW-1:0] cnt;
    logic          c_sync;
    logic          pins_run;
    logic          unused_pins;

    // a/b pins read back our own drive, so they carry no information.
    assign unused_pins = ^bus.ja_in[PIN_B:PIN_A];

    pin_sync #(.STAGES(SYNC_STAGES)) u_sync_c (
        .clk (clk),
        .rst (rst),
        .d   (bus.ja_in[PIN_C]),
        .q   (c_sync)
    );

    // Decoded from state so an async reset floats the pins at once and
    // the drive never drops to high-Z between back-to-back vectors.
    assign pins_run = (state == ST_DRIVE) || (state == ST_SETTLE) ||
                      (state == ST_SAMPLE);
    assign bus.ja_t   = pins_run ? JA_T_RUN : JA_T_IDLE;
    assign bus.ja_out = pins_run ? {1'b0, vec} : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            vec           <= 2'd0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
            bus.fail_mask <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bus.err_count <= 3'd0;
                        bus.fail_mask <= 4'd0;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.busy      <= 1'b1;
                        vec           <= 2'd0;
                        state         <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (c_sync != exp_c(vec)) begin
                        bus.err_count  <= bus.err_count + 3'd1;
                        bus.fail_mask[vec] <= 1'b1;
                    end
                    if (vec == 2'd3) begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end else begin
                        vec   <= vec + 2'd1;
                        state <= ST_DRIVE;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == TURN_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    bus.pass <= (bus.err_count == 3'd0);
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ja_pin_tester.sv
// Scoreboard bench for ja_pin_tester with an IOBUF + and_gate pin model.
// Stimulus queues expected results; a negedge monitor checks them on done.
module tb_ja_pin_tester;

    typedef struct {
        int         k;
        logic [2:0] err;
        logic [3:0] mask;
        logic       pass;
    } exp_t;

    logic clk;
    logic rst;
    logic clk_en;
    logic [1:0] mode;
    int   cyc;
    int   checks;
    int   errors;
    logic done_q;
    logic win_en;
    int   win_lo;
    int   win_hi;
    exp_t sb[$];
    exp_t mon_e;

    ja_pin_tester_if bus ();

    ja_pin_tester dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // IOBUFs + and_gate: an undriven pin reads 0; mode 1/2 force ja[2].
    logic pa, pb, pc;
    always_comb begin
        pa = !bus.ja_t[0] & bus.ja_out[0];
        pb = !bus.ja_t[1] & bus.ja_out[1];
        pc = pa & pb;
        if (mode == 2'd1) pc = 1'b0;
        if (mode == 2'd2) pc = 1'b1;
        bus.ja_in = {pc, pb, pa};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_latency", cyc - mon_e.k, 35);
                chk("err_count", bus.err_count, mon_e.err);
                chk("fail_mask", bus.fail_mask, mon_e.mask);
                chk("pass", bus.pass, mon_e.pass);
            end
        end
        done_q <= bus.done;
        if (!rst) chk("ja_t2_hiz", bus.ja_t[2], 1);
        if (win_en && cyc >= win_lo && cyc <= win_hi)
            chk("ja_t_run", bus.ja_t, 3'b100);
        if (win_en && cyc == win_hi + 1)
            chk("ja_t_release", bus.ja_t, 3'b111);
    end

    task automatic pulse_start(output int k);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = cyc;
        chk("busy_after_start", bus.busy, 1);
        win_lo = k;
        win_hi = k + 31;
        win_en = 1'b1;
    endtask

    task automatic run(input logic [2:0] e_err, input logic [3:0] e_mask,
                       input logic e_pass, input bit extra);
        int k;
        int t;
        exp_t e;
        pulse_start(k);
        e.k = k;
        e.err = e_err;
        e.mask = e_mask;
        e.pass = e_pass;
        sb.push_back(e);
        if (extra) begin
            while (cyc < k + 4) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            while (cyc < k + 19) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        t = 0;
        while (sb.size() != 0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        chk("busy_after_done", bus.busy, 0);
        chk("done_level", bus.done, 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ja_t", bus.ja_t, 3'b111);
        chk("rst_ja_out", bus.ja_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err_count", bus.err_count, 0);
        chk("rst_fail_mask", bus.fail_mask, 0);
    endtask

    task automatic reset_mid_run();
        int k;
        pulse_start(k);
        while (cyc < k + 19) @(negedge clk);
        #1;
        win_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", bus.done, 0);
        chk("idle_after_abort", bus.ja_t, 3'b111);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        clk_en = 1'b0;
        mode = 2'd0;
        win_en = 1'b0;
        win_lo = 0;
        win_hi = 0;
        done_q = 1'b0;
        bus.start = 1'b0;
        #2;
        rst = 1'b1;
        #3;
        check_reset_outputs();
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mode = 2'd0;
        run(3'd0, 4'b0000, 1'b1, 1'b0);
        mode = 2'd1;
        run(3'd1, 4'b1000, 1'b0, 1'b0);
        mode = 2'd2;
        run(3'd3, 4'b0111, 1'b0, 1'b0);
        mode = 2'd0;
        run(3'd0, 4'b0000, 1'b1, 1'b1);
        reset_mid_run();
        run(3'd0, 4'b0000, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
